// File: rtl/shift_normalizer_pkg.sv
// Shared definitions for the shift datapath: FSM states, barrel-shifter
// select encodings and the default operand width.
package shift_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SEARCH,
      DONE
   } state_t;

   localparam logic [2:0] SEL_SRL = 3'b000;
   localparam logic [2:0] SEL_SLL = 3'b001;
   localparam logic [2:0] SEL_ROR = 3'b010;
   localparam logic [2:0] SEL_ROL = 3'b011;
   localparam logic [2:0] SEL_SRA = 3'b110;

   localparam int WIDTH_DEFAULT = 16;

endpackage

// File: rtl/shift_normalizer_if.sv
// Operand/result handshake bundle for the normalizer; slave is the block side.
interface shift_normalizer_if #(parameter int WIDTH = 16);

   localparam int AMT_W = $clog2(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic             signed_mode;
   logic [WIDTH-1:0] origin_a;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] normalized;
   logic [AMT_W-1:0] norm_amount;
   logic             is_zero;

   modport master (
      output in_valid, signed_mode, origin_a, out_ready,
      input  in_ready, out_valid, normalized, norm_amount, is_zero
   );

   modport slave (
      input  in_valid, signed_mode, origin_a, out_ready,
      output in_ready, out_valid, normalized, norm_amount, is_zero
   );

endinterface

// File: rtl/shift_normalizer_lead_field_check.sv
// Flags whether the top n bits (unsigned) or top n+1 bits (signed) of a value
// carry no information, i.e. the value can be shifted left by n losslessly.
module lead_field_check #(
   parameter  int WIDTH = 16,
   localparam int AMT_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] value,
   input  logic [AMT_W:0]   n,
   input  logic             signed_mode,
   output logic             redundant
);

   logic [WIDTH-1:0] top_mask;
   logic [WIDTH-1:0] sign_mask;
   logic [WIDTH-1:0] sign_diff;

   // Bit gi sits DEPTH positions below the MSB; it belongs to the field when DEPTH < n.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
         localparam logic [AMT_W:0] DEPTH = (AMT_W+1)'(WIDTH - 1 - gi);
         assign top_mask[gi]  = (DEPTH < n);
         assign sign_mask[gi] = (DEPTH <= n);
      end
   endgenerate

   assign sign_diff = value ^ {WIDTH{value[WIDTH-1]}};
   assign redundant = signed_mode ? ((sign_diff & sign_mask) == '0)
                                  : ((value & top_mask) == '0);

endmodule

// File: rtl/shift_normalizer.sv
// Multi-cycle normalizer: binary-searches the left-shift amount MSB-first,
// one amount bit per cycle, and holds the result until the consumer accepts.
module shift_normalizer
   import shift_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   shift_normalizer_if.slave bus
);

   localparam int AMT_W = $clog2(WIDTH);

   state_t           state_reg,  state_next;
   logic [AMT_W-1:0] step_reg,   step_next;
   logic [AMT_W-1:0] amt_reg,    amt_next;
   logic [WIDTH-1:0] work_reg,   work_next;
   logic             zero_reg,   zero_next;
   logic             signed_reg, signed_next;

   logic [AMT_W:0]   n_val;
   logic             redundant;

   assign n_val = (AMT_W+1)'(1) << step_reg;

   lead_field_check #(.WIDTH(WIDTH)) u_check (
      .value       (work_reg),
      .n           (n_val),
      .signed_mode (signed_reg),
      .redundant   (redundant)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         step_reg   <= '0;
         amt_reg    <= '0;
         work_reg   <= '0;
         zero_reg   <= 1'b0;
         signed_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         step_reg   <= step_next;
         amt_reg    <= amt_next;
         work_reg   <= work_next;
         zero_reg   <= zero_next;
         signed_reg <= signed_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      step_next   = step_reg;
      amt_next    = amt_reg;
      work_next   = work_reg;
      zero_next   = zero_reg;
      signed_next = signed_reg;
      case (state_reg)
         IDLE: begin
            if (bus.in_valid) begin
               work_next   = bus.origin_a;
               signed_next = bus.signed_mode;
               zero_next   = (bus.origin_a == '0);
               amt_next    = '0;
               step_next   = AMT_W'(AMT_W - 1);
               state_next  = SEARCH;
            end
         end
         SEARCH: begin
            if (redundant) begin
               work_next          = work_reg << n_val;
               amt_next[step_reg] = 1'b1;
            end
            if (step_reg == '0) begin
               state_next = DONE;
            end else begin
               step_next = step_reg - 1'b1;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.in_ready    = (state_reg == IDLE);
   assign bus.out_valid   = (state_reg == DONE);
   assign bus.normalized  = work_reg;
   assign bus.norm_amount = amt_reg;
   assign bus.is_zero     = zero_reg;

endmodule

// File: tb/tb_shift_normalizer.sv
// Directed bench for shift_normalizer: hand-computed vectors, latency,
// backpressure, early out_ready and mid-search reset.
module tb_shift_normalizer;

   logic clk;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;

   shift_normalizer_if #(.WIDTH(16)) bus ();

   shift_normalizer #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Accept one operand; returns at #1 after the accept edge.
   task automatic start_op(input logic [15:0] a, input logic sm);
      int k = 0;
      while (bus.in_ready !== 1'b1 && k < 20) begin
         @(posedge clk); #1; k++;
      end
      check("in_ready_idle", {31'd0, bus.in_ready}, 32'd1);
      bus.in_valid    = 1'b1;
      bus.origin_a    = a;
      bus.signed_mode = sm;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check("in_ready_search", {31'd0, bus.in_ready}, 32'd0);
      check("out_valid_search", {31'd0, bus.out_valid}, 32'd0);
   endtask

   task automatic wait_done(input string tag);
      int lat = 0;
      while (bus.out_valid !== 1'b1 && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      check({tag, "_latency"}, lat, 32'd4);
   endtask

   task automatic check_result(input string tag, input logic [15:0] a, input logic sm,
                               input logic [15:0] en, input logic [3:0] ea, input logic ez);
      check({tag, "_norm"}, {16'd0, bus.normalized}, {16'd0, en});
      check({tag, "_amt"},  {28'd0, bus.norm_amount}, {28'd0, ea});
      check({tag, "_zero"}, {31'd0, bus.is_zero}, {31'd0, ez});
      $display("op %s a=0x%04h signed=%0d -> norm=0x%04h amt=%0d zero=%0d",
               tag, a, sm, bus.normalized, bus.norm_amount, bus.is_zero);
   endtask

   task automatic handshake(input string tag, input logic [15:0] en, input logic [3:0] ea);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check({tag, "_valid_drop"}, {31'd0, bus.out_valid}, 32'd0);
      check({tag, "_ready_back"}, {31'd0, bus.in_ready}, 32'd1);
      check({tag, "_norm_kept"}, {16'd0, bus.normalized}, {16'd0, en});
      check({tag, "_amt_kept"},  {28'd0, bus.norm_amount}, {28'd0, ea});
   endtask

   task automatic full_op(input string tag, input logic [15:0] a, input logic sm,
                          input logic [15:0] en, input logic [3:0] ea, input logic ez);
      start_op(a, sm);
      wait_done(tag);
      check_result(tag, a, sm, en, ea, ez);
      handshake(tag, en, ea);
   endtask

   initial begin
      rst_n           = 1'b0;
      bus.in_valid    = 1'b0;
      bus.origin_a    = '0;
      bus.signed_mode = 1'b0;
      bus.out_ready   = 1'b0;
      #3;
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_in_ready",  {31'd0, bus.in_ready}, 32'd1);
      check("rst_norm",      {16'd0, bus.normalized}, 32'd0);
      check("rst_amt",       {28'd0, bus.norm_amount}, 32'd0);
      check("rst_zero",      {31'd0, bus.is_zero}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      full_op("u0001", 16'h0001, 1'b0, 16'h8000, 4'd15, 1'b0);
      full_op("s0001", 16'h0001, 1'b1, 16'h4000, 4'd14, 1'b0);
      full_op("sfff0", 16'hFFF0, 1'b1, 16'h8000, 4'd11, 1'b0);
      full_op("u0000", 16'h0000, 1'b0, 16'h0000, 4'd15, 1'b1);
      full_op("s0000", 16'h0000, 1'b1, 16'h0000, 4'd15, 1'b1);
      full_op("sffff", 16'hFFFF, 1'b1, 16'h8000, 4'd15, 1'b0);
      full_op("u8123", 16'h8123, 1'b0, 16'h8123, 4'd0,  1'b0);
      full_op("s4000", 16'h4000, 1'b1, 16'h4000, 4'd0,  1'b0);
      full_op("u0123", 16'h0123, 1'b0, 16'h9180, 4'd7,  1'b0);

      // out_ready high throughout: result still appears after four steps.
      bus.out_ready = 1'b1;
      start_op(16'h0300, 1'b0);
      wait_done("early");
      check_result("early", 16'h0300, 1'b0, 16'hC000, 4'd6, 1'b0);
      handshake("early", 16'hC000, 4'd6);

      // Backpressure with a competing operand presented during DONE.
      start_op(16'h0F00, 1'b0);
      wait_done("bp");
      bus.in_valid    = 1'b1;
      bus.origin_a    = 16'h0001;
      bus.signed_mode = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("bp_valid", {31'd0, bus.out_valid}, 32'd1);
         check("bp_ready", {31'd0, bus.in_ready}, 32'd0);
         check("bp_norm",  {16'd0, bus.normalized}, 32'h0000F000);
         check("bp_amt",   {28'd0, bus.norm_amount}, 32'd4);
      end
      bus.in_valid = 1'b0;
      check_result("bp", 16'h0F00, 1'b0, 16'hF000, 4'd4, 1'b0);
      handshake("bp", 16'hF000, 4'd4);

      // Reset while the search is at step 2.
      start_op(16'h1234, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("mrst_valid", {31'd0, bus.out_valid}, 32'd0);
      check("mrst_ready", {31'd0, bus.in_ready}, 32'd1);
      check("mrst_norm",  {16'd0, bus.normalized}, 32'd0);
      check("mrst_amt",   {28'd0, bus.norm_amount}, 32'd0);
      check("mrst_zero",  {31'd0, bus.is_zero}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         check("mrst_no_output", {31'd0, bus.out_valid}, 32'd0);
      end
      $display("op mrst a=0x1234 discarded by reset");
      full_op("u00f0", 16'h00F0, 1'b0, 16'hF000, 4'd8, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
